// File: rtl/addsub_pkg.sv
// Shared encodings and constants for the pipelined add/subtract unit.
package addsub_pkg;

  // Operation select encoding
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SBB = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  // Bit positions within a packed {C, V, N, Z} flag vector
  localparam int unsigned F_Z    = 0;
  localparam int unsigned F_N    = 1;
  localparam int unsigned F_V    = 2;
  localparam int unsigned F_C    = 3;
  localparam int unsigned NFLAGS = 4;

  // Widest operand the saturation helper can describe
  localparam int unsigned MAX_W = 256;

  // Signed max (neg=0) or signed min (neg=1) for a w-bit two's-complement value,
  // zero-extended to MAX_W bits; callers take the low w bits.
  function automatic logic [MAX_W-1:0] sat_limit(input int unsigned w, input logic neg);
    logic [MAX_W-1:0] msb;
    msb = MAX_W'(1) << (w - 1);
    return neg ? msb : (msb - MAX_W'(1));
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG_W-bit slice of the segmented carry chain.
module addsub_seg #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  // Plain ripple add of the slice with its incoming carry
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub/sbb/cmp unit: one SEG_W-bit carry segment resolved per
// stage, valid/ready on both sides, flags and optional signed saturation.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SEG_W    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag,
  output logic             carry_flag
);

  localparam int unsigned NSTG = WIDTH / SEG_W;
  localparam int unsigned LAST = NSTG - 1;

  localparam logic [MAX_W-1:0] SMAX_FULL = sat_limit(WIDTH, 1'b0);
  localparam logic [MAX_W-1:0] SMIN_FULL = sat_limit(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0] SMAX      = SMAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN      = SMIN_FULL[WIDTH-1:0];

  // Per-stage registers
  logic [NSTG-1:0]  v_q;
  logic [WIDTH-1:0] a_q  [NSTG];
  logic [WIDTH-1:0] b_q  [NSTG];
  logic [WIDTH-1:0] s_q  [NSTG];
  logic             c_q  [NSTG];
  logic [1:0]       op_q [NSTG];

  // Per-stage next-state / stage inputs
  logic [NSTG-1:0]  v_d;
  logic [WIDTH-1:0] a_d   [NSTG];
  logic [WIDTH-1:0] b_d   [NSTG];
  logic [WIDTH-1:0] sin_d [NSTG];
  logic [WIDTH-1:0] s_d   [NSTG];
  logic             cin_d [NSTG];
  logic             c_d   [NSTG];
  logic [1:0]       op_d  [NSTG];
  logic [SEG_W-1:0] seg_sum [NSTG];

  logic [NSTG-1:0]  adv;
  logic [WIDTH-1:0] b_prep;
  logic             cin0;

  // Operand preparation: invert B and pick the carry-in for the subtract modes
  always_comb begin
    b_prep = (op == OP_ADD) ? b : ~b;
    cin0   = 1'b0;
    case (op)
      OP_ADD:  cin0 = 1'b0;
      OP_SBB:  cin0 = ~borrow_in;
      default: cin0 = 1'b1;
    endcase
  end

  // Stage k advances unless stage k and every stage after it is full while
  // the output is stalled; the ready chain is flattened to avoid a comb loop.
  always_comb begin
    adv = '0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      logic full;
      full = 1'b1;
      for (int unsigned j = k; j < NSTG; j++) full &= v_q[j];
      adv[k] = ~full | out_ready;
    end
  end

  assign in_ready = adv[0];

  // Route each stage's inputs: ports for stage 0, previous stage otherwise
  always_comb begin
    v_d = '0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      if (k == 0) begin
        v_d[k]   = in_valid;
        a_d[k]   = a;
        b_d[k]   = b_prep;
        sin_d[k] = '0;
        cin_d[k] = cin0;
        op_d[k]  = op;
      end else begin
        v_d[k]   = v_q[k-1];
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        sin_d[k] = s_q[k-1];
        cin_d[k] = c_q[k-1];
        op_d[k]  = op_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_seg
    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .a    (a_d[k][k*SEG_W +: SEG_W]),
      .b    (b_d[k][k*SEG_W +: SEG_W]),
      .cin  (cin_d[k]),
      .sum  (seg_sum[k]),
      .cout (c_d[k])
    );
  end

  // Merge the freshly resolved slice into the partial sum
  always_comb begin
    for (int unsigned k = 0; k < NSTG; k++) begin
      s_d[k] = sin_d[k];
      s_d[k][k*SEG_W +: SEG_W] = seg_sum[k];
    end
  end

  // Pipeline registers: load on advance, clear everything on reset
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NSTG; k++) begin
      if (rst) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        op_q[k] <= OP_ADD;
      end else if (adv[k]) begin
        v_q[k]  <= v_d[k];
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        s_q[k]  <= s_d[k];
        c_q[k]  <= c_d[k];
        op_q[k] <= op_d[k];
      end
    end
  end

  logic [WIDTH-1:0] sum_f;
  logic [WIDTH-1:0] res_f;
  logic             a_msb;
  logic             b_msb;
  logic             ovf;

  // Flags and saturation from the last stage; outputs read zero when empty
  always_comb begin
    sum_f = s_q[LAST];
    a_msb = a_q[LAST][WIDTH-1];
    b_msb = b_q[LAST][WIDTH-1];
    ovf   = (a_msb == b_msb) && (sum_f[WIDTH-1] != a_msb);
    res_f = sum_f;
    if (SATURATE && ovf) res_f = a_msb ? SMIN : SMAX;

    out_valid     = v_q[LAST];
    result        = '0;
    zero_flag     = 1'b0;
    negative_flag = 1'b0;
    overflow_flag = 1'b0;
    carry_flag    = 1'b0;
    if (v_q[LAST]) begin
      result        = (op_q[LAST] == OP_CMP) ? '0 : res_f;
      zero_flag     = (res_f == '0);
      negative_flag = res_f[WIDTH-1];
      overflow_flag = ovf;
      carry_flag    = (op_q[LAST] == OP_ADD) ? c_q[LAST] : ~c_q[LAST];
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three lockstep instances (32/8 plain, 32/8 saturating,
// 64/16 plain) driven cycle by cycle against an arithmetic reference model.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int unsigned NSTG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, borrow_in;
  logic [1:0]  op;
  logic [63:0] a64, b64;

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] r0, r1;
  logic [63:0] r2;
  logic        z0, n0, v0, c0, z1, n1, v1, c1, z2, n2, v2, c2;
  logic [3:0]  f0, f1, f2;

  addsub_pipe #(.WIDTH(32), .SEG_W(8), .SATURATE(1'b0)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a64[31:0]), .b(b64[31:0]), .op(op), .borrow_in(borrow_in),
    .out_valid(ov0), .out_ready(out_ready), .result(r0),
    .zero_flag(z0), .negative_flag(n0), .overflow_flag(v0), .carry_flag(c0));

  addsub_pipe #(.WIDTH(32), .SEG_W(8), .SATURATE(1'b1)) d32s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a64[31:0]), .b(b64[31:0]), .op(op), .borrow_in(borrow_in),
    .out_valid(ov1), .out_ready(out_ready), .result(r1),
    .zero_flag(z1), .negative_flag(n1), .overflow_flag(v1), .carry_flag(c1));

  addsub_pipe #(.WIDTH(64), .SEG_W(16), .SATURATE(1'b0)) d64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a64), .b(b64), .op(op), .borrow_in(borrow_in),
    .out_valid(ov2), .out_ready(out_ready), .result(r2),
    .zero_flag(z2), .negative_flag(n2), .overflow_flag(v2), .carry_flag(c2));

  always_comb begin
    f0 = '0; f0[F_Z] = z0; f0[F_N] = n0; f0[F_V] = v0; f0[F_C] = c0;
    f1 = '0; f1[F_Z] = z1; f1[F_N] = n1; f1[F_V] = v1; f1[F_C] = c1;
    f2 = '0; f2[F_Z] = z2; f2[F_N] = n2; f2[F_V] = v2; f2[F_C] = c2;
  end

  typedef struct {
    int unsigned acc;
    logic [63:0] r0, r1, r2;
    logic [3:0]  f0, f1, f2;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned edges = 0;
  bit          after_rst = 1'b0;

  // Exact integer arithmetic: signed result checked against the w-bit range,
  // borrow as an unsigned comparison, then clamp / flag / CMP zeroing.
  function automatic void ref_model(input int unsigned w, input bit sat,
                                    input logic [63:0] av, input logic [63:0] bv,
                                    input logic [1:0] opv, input logic bi,
                                    output logic [63:0] res, output logic [3:0] fl);
    logic [63:0]        mask, r;
    logic signed [69:0] sa, sb, sr, smax, smin, ks;
    logic [69:0]        ua, ub, ur;
    logic               c, v;
    mask = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    ua   = {6'b0, av & mask};
    ub   = {6'b0, bv & mask};
    sa   = (w == 64) ? {{6{av[63]}}, av} : {{38{av[31]}}, av[31:0]};
    sb   = (w == 64) ? {{6{bv[63]}}, bv} : {{38{bv[31]}}, bv[31:0]};
    smax = (70'sd1 <<< (w - 1)) - 70'sd1;
    smin = -(70'sd1 <<< (w - 1));
    ks   = (opv == OP_SBB && bi) ? 70'sd1 : 70'sd0;
    if (opv == OP_ADD) begin
      ur = ua + ub;
      c  = ur[w];
      sr = sa + sb;
    end else begin
      ur = ua - ub - ks;
      c  = (ua < ub + ks);
      sr = sa - sb - ks;
    end
    v = (sr > smax) || (sr < smin);
    r = ur[63:0] & mask;
    if (sat && v) r = (sr < 0) ? (smin[63:0] & mask) : smax[63:0];
    fl = '0;
    fl[F_Z] = (r == '0);
    fl[F_N] = r[w-1];
    fl[F_V] = v;
    fl[F_C] = c;
    res = (opv == OP_CMP) ? '0 : r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, update the model
  task automatic step(input logic iv, input logic ordy, input logic [1:0] opv,
                      input logic [63:0] av, input logic [63:0] bv,
                      input logic bi, input logic r);
    exp_t e;
    logic exp_ir, exp_ov;
    @(negedge clk);
    rst = r; in_valid = iv; out_ready = ordy; op = opv;
    a64 = av; b64 = bv; borrow_in = bi;
    #1;
    if (!r) begin
      exp_ir = (q.size() < NSTG) || ordy;
      chk("in_ready32",  {63'b0, ir0}, {63'b0, exp_ir});
      chk("in_ready32s", {63'b0, ir1}, {63'b0, exp_ir});
      chk("in_ready64",  {63'b0, ir2}, {63'b0, exp_ir});
      exp_ov = 1'b0;
      if (q.size() > 0) exp_ov = (edges >= q[0].acc + NSTG);
      chk("out_valid32",  {63'b0, ov0}, {63'b0, exp_ov});
      chk("out_valid32s", {63'b0, ov1}, {63'b0, exp_ov});
      chk("out_valid64",  {63'b0, ov2}, {63'b0, exp_ov});
      if (after_rst) begin
        chk("rst_result32",  {32'b0, r0}, '0);
        chk("rst_flags32",   {60'b0, f0}, '0);
        chk("rst_result32s", {32'b0, r1}, '0);
        chk("rst_flags32s",  {60'b0, f1}, '0);
        chk("rst_result64",  r2, '0);
        chk("rst_flags64",   {60'b0, f2}, '0);
      end
      if (exp_ov) begin
        chk("result32",  {32'b0, r0}, q[0].r0);
        chk("flags32",   {60'b0, f0}, {60'b0, q[0].f0});
        chk("result32s", {32'b0, r1}, q[0].r1);
        chk("flags32s",  {60'b0, f1}, {60'b0, q[0].f1});
        chk("result64",  r2, q[0].r2);
        chk("flags64",   {60'b0, f2}, {60'b0, q[0].f2});
        if (ordy) void'(q.pop_front());
      end
      if (iv && exp_ir) begin
        e.acc = edges;
        ref_model(32, 1'b0, av, bv, opv, bi, e.r0, e.f0);
        ref_model(32, 1'b1, av, bv, opv, bi, e.r1, e.f1);
        ref_model(64, 1'b0, av, bv, opv, bi, e.r2, e.f2);
        q.push_back(e);
      end
    end else begin
      q.delete();
    end
    after_rst = r;
    @(posedge clk);
    edges++;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) step(1'b0, 1'b1, OP_ADD, '0, '0, 1'b0, 1'b0);
    chk("drain_left", 64'(q.size()), '0);
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] x;
    case ($urandom_range(0, 8))
      0:       x = '0;
      1:       x = 64'd1;
      2:       x = 64'h0000_0000_7FFF_FFFF;
      3:       x = 64'h0000_0000_8000_0000;
      4:       x = 64'h7FFF_FFFF_FFFF_FFFF;
      5:       x = 64'h8000_0000_0000_0000;
      6:       x = '1;
      7:       x = 64'hFFFF_FFFF_8000_0000;
      default: x = {$urandom, $urandom};
    endcase
    return x;
  endfunction

  logic [1:0]  d_op [11];
  logic [63:0] d_a  [11];
  logic [63:0] d_b  [11];
  logic        d_bi [11];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = OP_ADD;
    a64 = '0; b64 = '0; borrow_in = 1'b0;

    d_op[0]  = OP_ADD; d_a[0]  = 64'h0000_0000_7FFF_FFFF; d_b[0]  = 64'd1; d_bi[0]  = 1'b0;
    d_op[1]  = OP_SUB; d_a[1]  = 64'd5;                   d_b[1]  = 64'd5; d_bi[1]  = 1'b0;
    d_op[2]  = OP_SUB; d_a[2]  = 64'd3;                   d_b[2]  = 64'd5; d_bi[2]  = 1'b0;
    d_op[3]  = OP_SUB; d_a[3]  = 64'h0000_0000_8000_0000; d_b[3]  = 64'd1; d_bi[3]  = 1'b0;
    d_op[4]  = OP_SBB; d_a[4]  = 64'h100;                 d_b[4]  = 64'd1; d_bi[4]  = 1'b1;
    d_op[5]  = OP_CMP; d_a[5]  = 64'd7;                   d_b[5]  = 64'd9; d_bi[5]  = 1'b0;
    d_op[6]  = OP_ADD; d_a[6]  = 64'hFFFF_FFFF_FFFF_FFFF; d_b[6]  = 64'd1; d_bi[6]  = 1'b0;
    d_op[7]  = OP_ADD; d_a[7]  = 64'h7FFF_FFFF_FFFF_FFFF; d_b[7]  = 64'd1; d_bi[7]  = 1'b0;
    d_op[8]  = OP_SUB; d_a[8]  = 64'h8000_0000_0000_0000; d_b[8]  = 64'd1; d_bi[8]  = 1'b0;
    d_op[9]  = OP_SBB; d_a[9]  = 64'd0;                   d_b[9]  = 64'd0; d_bi[9]  = 1'b1;
    d_op[10] = OP_SBB; d_a[10] = 64'd9;                   d_b[10] = 64'd4; d_bi[10] = 1'b0;

    // reset, then idle state right after it
    step(1'b0, 1'b1, OP_ADD, '0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, OP_ADD, '0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, OP_ADD, '0, '0, 1'b0, 1'b0);

    // directed corner cases, back to back
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, d_op[i], d_a[i], d_b[i], d_bi[i], 1'b0);
    drain();

    // random stream with random back-pressure
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // fill the pipe under stall, then simultaneous in/out accept at full occupancy
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // reset with three beats in flight, then a fresh beat
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 1'b0);
    step(1'b0, 1'b1, OP_ADD, '0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, OP_SUB, 64'h0000_0000_8000_0000, 64'd1, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement add/subtract unit with flag generation. It is the next generation of the fixed 32-bit subtractor in the ALU datapath.
- The carry chain is split into SEG_W-bit segments, one segment per pipeline stage, so wide operands meet timing.
- Adds op modes (add, sub, sub-with-borrow, compare) and optional signed saturation.
- Uses valid/ready handshakes on both sides. Sits between the ALU operand-select stage and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG_W, minimum 8.
- SEG_W, 8, bits resolved per stage; NSTG = WIDTH/SEG_W stages. Latency = NSTG cycles.
- SATURATE, 0, 1 = clamp signed overflow to the signed max/min value.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD, 01 SUB, 10 SBB (A-B-borrow_in), 11 CMP.
- borrow_in  input  1  used only by SBB.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts.
- result  output  WIDTH  sum/difference (all zeros for CMP).
- zero_flag  output  1  Z.
- negative_flag  output  1  N.
- overflow_flag  output  1  V (signed overflow).
- carry_flag  output  1  ADD: carry-out. SUB/SBB/CMP: borrow = ~carry-out.

Behaviour:
- Reset (rst=1 at clk edge): every stage valid bit cleared. out_valid=0, result=0, all flags 0. in_ready=1 from the cycle after reset.
- Reset mid-operation: in-flight beats are dropped silently.
- Operand preparation, stage 0 input:
  - B' = ~b for SUB/SBB/CMP, b for ADD.
  - cin = 0 for ADD, 1 for SUB/CMP, ~borrow_in for SBB.
- Stage k (0..NSTG-1):
  - Adds slice [k*SEG_W +: SEG_W] of A and B' with the carry from stage k-1.
  - Registers the partial sum, the carry, and the unresolved upper slices of A and B'.
  - Forwards a[WIDTH-1], b'[WIDTH-1] and op alongside the data.
- Final stage computes the flags:
  - C = cout (ADD) or ~cout (others).
  - V = (A_msb == B'_msb) && (sum_msb != A_msb).
  - SATURATE=1 and V=1: result = A_msb ? {1,0...0} : {0,1...1}. V is still reported.
  - N and Z are computed on the final (possibly clamped) result, before the CMP zeroing. For CMP, result output = 0 while the flags reflect A-B.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - Stage i advances when it is empty, or stage i+1 advances, or (i = last) out_ready=1.
  - in_ready = stage 0 can advance. It is combinational from out_ready through the chain; no bubble is inserted.
  - Full throughput: 1 beat/cycle when out_ready stays high.
- Back-pressure: while out_valid=1 and out_ready=0, result and flags hold stable. Upstream stages fill; in_ready drops once every stage holds a beat.
- Ordering is strictly in-order. Nothing is dropped or duplicated.
- Simultaneous accept on input and output with a full pipe: allowed, and the occupancy stays the same.
- Width rule: all arithmetic is modulo 2^WIDTH. The carry out of the top segment is the only carry exported.

Decomposition:
- Package addsub_pkg:
  - op encoding localparams OP_ADD / OP_SUB / OP_SBB / OP_CMP.
  - flag-vector index constants F_Z / F_N / F_V / F_C.
  - a function returning the signed max/min constant for a given WIDTH.
- Sub-module addsub_seg: SEG_W-bit combinational slice adder (a, b, cin -> sum, cout). It is instantiated once per stage inside a generate loop. The pipeline registers and handshake stay in addsub_pipe.

Test Plan (WIDTH=32, SEG_W=8, latency 4 unless noted):
- ADD 0x7FFFFFFF+0x00000001, SATURATE=0 -> 4 cycles later result 0x80000000, N=1, V=1, C=0, Z=0.
- SUB 5-5 -> result 0, Z=1, C=0. SUB 3-5 -> 0xFFFFFFFE, N=1, C=1 (borrow), V=0.
- SUB 0x80000000-1 with SATURATE=1 -> result 0x80000000 (clamped), V=1, N=1. The same beat with SATURATE=0 gives 0x7FFFFFFF.
- SBB 0x100-0x1 with borrow_in=1 -> 0x000000FE. CMP 7 vs 9 -> result 0, N=1, C=1.
- Stream of 16 beats with out_ready toggling pseudo-randomly -> results in order, outputs stable while stalled, in_ready=0 only when all 4 stages are full, full throughput when out_ready=1.
- Assert rst with 3 beats in flight -> the next cycle out_valid=0 and all outputs 0. The first beat after reset returns with 4-cycle latency. Repeat with WIDTH=64, SEG_W=16.
